// File: rtl/sr_lsu_ctrl_pkg.sv
// Shared types and constants for the load/store sequencer: FSM states,
// access size codes and the RV32 load/store funct3 encodings.
package sr_lsu_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_RESP,
        ST_DONE
    } lsu_state_t;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10,
        SZ_X = 2'b11
    } lsu_size_t;

    localparam logic [2:0] RVF3_LB  = 3'b000;
    localparam logic [2:0] RVF3_LH  = 3'b001;
    localparam logic [2:0] RVF3_LW  = 3'b010;
    localparam logic [2:0] RVF3_LBU = 3'b100;
    localparam logic [2:0] RVF3_LHU = 3'b101;
    localparam logic [2:0] RVF3_SB  = 3'b000;
    localparam logic [2:0] RVF3_SH  = 3'b001;
    localparam logic [2:0] RVF3_SW  = 3'b010;

    function automatic logic is_aligned(input lsu_size_t sz, input logic [1:0] lo);
        case (sz)
            SZ_B:    return 1'b1;
            SZ_H:    return ~lo[0];
            SZ_W:    return (lo == 2'b00);
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/sr_lsu_align.sv
// Combinational lane logic: legality check, byte enables, store-data
// replication and load-data lane select with sign/zero extension.
module sr_lsu_align
    import sr_lsu_ctrl_pkg::*;
(
    input  logic        is_load,
    input  logic        is_store,
    input  logic [2:0]  f3,
    input  logic [1:0]  lo,
    input  logic [31:0] wdata,
    output logic        legal,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    input  lsu_size_t   ld_size,
    input  logic        ld_unsigned,
    input  logic [1:0]  ld_lo,
    input  logic [31:0] rword,
    output logic [31:0] ldata
);

    lsu_size_t   size;
    logic        f3_ok;
    logic [31:0] shifted;

    assign size = lsu_size_t'(f3[1:0]);

    always_comb begin
        f3_ok = 1'b0;
        if (is_load)
            f3_ok = f3 inside {RVF3_LB, RVF3_LH, RVF3_LW, RVF3_LBU, RVF3_LHU};
        else if (is_store)
            f3_ok = f3 inside {RVF3_SB, RVF3_SH, RVF3_SW};
        // a simultaneous load and store is never a legal access
        legal = (is_load ^ is_store) && f3_ok && is_aligned(size, lo);
    end

    always_comb begin
        be        = '0;
        wdata_rep = '0;
        case (size)
            SZ_B: begin
                be        = 4'b0001 << lo;
                wdata_rep = {4{wdata[7:0]}};
            end
            SZ_H: begin
                be        = 4'b0011 << lo;
                wdata_rep = {2{wdata[15:0]}};
            end
            SZ_W: begin
                be        = '1;
                wdata_rep = wdata;
            end
            default: ;
        endcase
    end

    assign shifted = rword >> {ld_lo, 3'b000};

    always_comb begin
        ldata = '0;
        case (ld_size)
            SZ_B:    ldata = {{24{~ld_unsigned & shifted[7]}}, shifted[7:0]};
            SZ_H:    ldata = {{16{~ld_unsigned & shifted[15]}}, shifted[15:0]};
            SZ_W:    ldata = rword;
            default: ;
        endcase
    end

endmodule

// File: rtl/sr_lsu_ctrl.sv
// Load/store sequencer: issues one handshaked memory transaction per access,
// stalls the core until it completes, and returns extended load data.
module sr_lsu_ctrl
    import sr_lsu_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic [2:0]  cmdF3,
    input  logic [31:0] addr,
    input  logic [31:0] wdataIn,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        rdValid,
    output logic        accessErr,
    output logic        timeout,
    output logic        dmemReq,
    output logic        dmemWe,
    output logic [31:0] dmemAddr,
    output logic [3:0]  dmemBe,
    output logic [31:0] dmemWdata,
    input  logic        dmemReady,
    input  logic        dmemRvalid,
    input  logic [31:0] dmemRdata
);

    lsu_state_t  state;
    logic [31:0] tcnt;
    lsu_size_t   cap_size;
    logic        cap_uns;
    logic [1:0]  cap_lo;

    logic        access;
    logic        legal;
    logic        start;
    logic        expire;
    logic [3:0]  be_n;
    logic [31:0] wrep;
    logic [31:0] ldata;

    assign access = memRead | memWrite;

    sr_lsu_align u_align (
        .is_load     (memRead),
        .is_store    (memWrite),
        .f3          (cmdF3),
        .lo          (addr[1:0]),
        .wdata       (wdataIn),
        .legal       (legal),
        .be          (be_n),
        .wdata_rep   (wrep),
        .ld_size     (cap_size),
        .ld_unsigned (cap_uns),
        .ld_lo       (cap_lo),
        .rword       (dmemRdata),
        .ldata       (ldata)
    );

    // stall and accessErr must act in the access's first cycle, so they stay
    // combinational while every other output is registered in the FSM
    assign start     = (state == ST_IDLE) && access && legal;
    assign accessErr = (state == ST_IDLE) && access && !legal;
    assign stall     = start || (state == ST_REQ) || (state == ST_RESP);
    assign expire    = (TIMEOUT != 0) && (tcnt == TIMEOUT - 1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            tcnt      <= '0;
            dmemReq   <= 1'b0;
            dmemWe    <= 1'b0;
            dmemAddr  <= '0;
            dmemBe    <= '0;
            dmemWdata <= '0;
            rdata     <= '0;
            rdValid   <= 1'b0;
            timeout   <= 1'b0;
            cap_size  <= SZ_B;
            cap_uns   <= 1'b0;
            cap_lo    <= '0;
        end else begin
            rdValid <= 1'b0;
            timeout <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state     <= ST_REQ;
                        tcnt      <= '0;
                        dmemReq   <= 1'b1;
                        dmemWe    <= memWrite;
                        dmemAddr  <= {addr[31:2], 2'b00};
                        dmemBe    <= be_n;
                        dmemWdata <= wrep;
                        cap_size  <= lsu_size_t'(cmdF3[1:0]);
                        cap_uns   <= cmdF3[2];
                        cap_lo    <= addr[1:0];
                    end
                end
                ST_REQ: begin
                    tcnt <= tcnt + 32'd1;
                    // completion is tested before expiry so it wins a tie
                    if (dmemReady && (dmemWe || dmemRvalid)) begin
                        state   <= ST_DONE;
                        dmemReq <= 1'b0;
                        if (!dmemWe) begin
                            rdata   <= ldata;
                            rdValid <= 1'b1;
                        end
                    end else if (expire) begin
                        state   <= ST_DONE;
                        dmemReq <= 1'b0;
                        rdata   <= '0;
                        timeout <= 1'b1;
                    end else if (dmemReady) begin
                        state   <= ST_RESP;
                        dmemReq <= 1'b0;
                    end
                end
                ST_RESP: begin
                    tcnt <= tcnt + 32'd1;
                    if (dmemRvalid) begin
                        state   <= ST_DONE;
                        rdata   <= ldata;
                        rdValid <= 1'b1;
                    end else if (expire) begin
                        state   <= ST_DONE;
                        rdata   <= '0;
                        timeout <= 1'b1;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sr_lsu_ctrl.sv
// Bench for sr_lsu_ctrl: directed spec scenarios plus randomized accesses
// checked against a transaction-level model of latency, lanes and extension.
module tb_sr_lsu_ctrl;

    localparam int TB_TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        memRead, memWrite;
    logic [2:0]  cmdF3;
    logic [31:0] addr, wdataIn;
    logic        stall, rdValid, accessErr, timeout;
    logic [31:0] rdata;
    logic        dmemReq, dmemWe;
    logic [31:0] dmemAddr, dmemWdata;
    logic [3:0]  dmemBe;
    logic        dmemReady, dmemRvalid;
    logic [31:0] dmemRdata;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] last_rdata = '0;

    typedef struct packed {
        logic        done;
        logic        err;
        logic        rdv;
        logic        to;
        logic        we;
        logic        post_idle;
        logic [7:0]  stall_cyc;
        logic [7:0]  req_cyc;
        logic [7:0]  rdv_cnt;
        logic [7:0]  to_cnt;
        logic [31:0] daddr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [3:0]  be;
    } obs_t;

    always #5 clk = ~clk;

    sr_lsu_ctrl #(.TIMEOUT(TB_TIMEOUT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .memRead    (memRead),
        .memWrite   (memWrite),
        .cmdF3      (cmdF3),
        .addr       (addr),
        .wdataIn    (wdataIn),
        .stall      (stall),
        .rdata      (rdata),
        .rdValid    (rdValid),
        .accessErr  (accessErr),
        .timeout    (timeout),
        .dmemReq    (dmemReq),
        .dmemWe     (dmemWe),
        .dmemAddr   (dmemAddr),
        .dmemBe     (dmemBe),
        .dmemWdata  (dmemWdata),
        .dmemReady  (dmemReady),
        .dmemRvalid (dmemRvalid),
        .dmemRdata  (dmemRdata)
    );

    // Transaction-level expectation: memory accepts in REQ cycle rdy, read data
    // follows rv cycles later; the access ends at that index or at TIMEOUT-1.
    function automatic obs_t model(input logic rd, input logic wr, input logic [2:0] f3,
                                   input logic [31:0] a, input logic [31:0] wd,
                                   input logic [31:0] rw, input int rdy, input int rv,
                                   input logic [31:0] prev);
        obs_t e;
        logic ok;
        int compl, endi;
        logic [31:0] v;
        e = '0;
        case (f3[1:0])
            2'd0:    ok = 1'b1;
            2'd1:    ok = (a[0] == 1'b0);
            2'd2:    ok = (a[1:0] == 2'd0);
            default: ok = 1'b0;
        endcase
        if (rd && (f3 == 3'b110 || f3 == 3'b111)) ok = 1'b0;
        if (wr && f3[2]) ok = 1'b0;
        if (rd && wr) ok = 1'b0;
        if (!(rd || wr)) return e;
        if (!ok) begin
            e.err = 1'b1;
            return e;
        end
        compl = wr ? rdy : rdy + rv;
        e.to  = (TB_TIMEOUT > 0) && (compl > TB_TIMEOUT - 1);
        endi  = e.to ? TB_TIMEOUT - 1 : compl;
        e.done      = 1'b1;
        e.post_idle = 1'b1;
        e.stall_cyc = 8'(endi + 2);
        e.req_cyc   = 8'(((rdy < endi) ? rdy : endi) + 1);
        e.daddr     = a & 32'hFFFF_FFFC;
        e.we        = wr;
        v = rw >> (8 * int'(a[1:0]));
        case (f3[1:0])
            2'd0: begin
                e.be    = 4'(1 << a[1:0]);
                e.wdata = (wd & 32'hFF) * 32'h0101_0101;
                v = v & 32'hFF;
                if (!f3[2] && v >= 32'h80) v = v + 32'hFFFF_FF00;
            end
            2'd1: begin
                e.be    = 4'(3 << a[1:0]);
                e.wdata = (wd & 32'hFFFF) * 32'h0001_0001;
                v = v & 32'hFFFF;
                if (!f3[2] && v >= 32'h8000) v = v + 32'hFFFF_0000;
            end
            default: begin
                e.be    = 4'hF;
                e.wdata = wd;
                v = rw;
            end
        endcase
        e.rdv     = rd && !e.to;
        e.rdv_cnt = {7'd0, e.rdv};
        e.to_cnt  = {7'd0, e.to};
        e.rdata   = e.to ? 32'd0 : (rd ? v : prev);
        return e;
    endfunction

    // Drives one access and plays the memory side; returns what was observed.
    task automatic drive_access(input logic rd, input logic wr, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] wd,
                                input logic [31:0] rw, input int rdy, input int rv,
                                output obs_t o);
        int j;
        o = '0;
        memRead = rd; memWrite = wr; cmdF3 = f3; addr = a; wdataIn = wd;
        dmemReady = 1'b0; dmemRvalid = 1'b0;
        #1;
        o.err = accessErr;
        if (stall) o.stall_cyc = 8'd1;
        if (!stall) begin
            for (int k = 0; k < 2; k++) begin
                @(negedge clk);
                if (dmemReq) o.req_cyc += 8'd1;
                if (stall) o.stall_cyc += 8'd1;
            end
            memRead = 1'b0; memWrite = 1'b0;
            return;
        end
        j = 0;
        for (int k = 0; k < 64 && !o.done; k++) begin
            @(negedge clk);
            if (rdValid) o.rdv_cnt += 8'd1;
            if (timeout) o.to_cnt += 8'd1;
            if (stall) begin
                o.stall_cyc += 8'd1;
                if (dmemReq) begin
                    if (o.req_cyc == 8'd0) begin
                        o.daddr = dmemAddr; o.be = dmemBe; o.wdata = dmemWdata; o.we = dmemWe;
                    end
                    o.req_cyc += 8'd1;
                end
                dmemReady  = dmemReq && (j == rdy);
                dmemRvalid = rd && (j == rdy + rv);
                dmemRdata  = (j == rdy + rv) ? rw : $urandom();
                j++;
            end else begin
                o.done  = 1'b1;
                o.rdata = rdata;
                o.rdv   = rdValid;
                o.to    = timeout;
                dmemReady = 1'b0; dmemRvalid = 1'b0;
                memRead = 1'b0; memWrite = 1'b0;
            end
        end
        memRead = 1'b0; memWrite = 1'b0; dmemReady = 1'b0; dmemRvalid = 1'b0;
        @(negedge clk);
        if (rdValid) o.rdv_cnt += 8'd1;
        if (timeout) o.to_cnt += 8'd1;
        o.post_idle = !stall && !dmemReq;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall: got %b expected 0", stall); end
        n_checks++; if (dmemReq !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b expected 0", dmemReq); end
        n_checks++; if (rdValid !== 1'b0) begin n_fail++; $display("FAIL rst_rdvalid: got %b expected 0", rdValid); end
        n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL rst_timeout: got %b expected 0", timeout); end
        n_checks++; if (accessErr !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b expected 0", accessErr); end
        n_checks++; if (rdata !== 32'd0) begin n_fail++; $display("FAIL rst_rdata: got %h expected 0", rdata); end
        n_checks++; if ({dmemWe, dmemBe, dmemAddr, dmemWdata} !== '0) begin
            n_fail++; $display("FAIL rst_dmem: got we=%b be=%h a=%h wd=%h expected all 0", dmemWe, dmemBe, dmemAddr, dmemWdata);
        end
        rst_n = 1'b1;
        last_rdata = '0;
    endtask

    task automatic test_store_word();
        obs_t o;
        drive_access(1'b0, 1'b1, 3'b010, 32'h104, 32'hDEADBEEF, 32'h0, 0, 0, o);
        n_checks++; if (o.done !== 1'b1) begin n_fail++; $display("FAIL sw_done: got %b expected 1", o.done); end
        n_checks++; if (o.be !== 4'hF) begin n_fail++; $display("FAIL sw_be: got %h expected f", o.be); end
        n_checks++; if (o.daddr !== 32'h104) begin n_fail++; $display("FAIL sw_addr: got %h expected 00000104", o.daddr); end
        n_checks++; if (o.wdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL sw_wdata: got %h expected deadbeef", o.wdata); end
        n_checks++; if (o.we !== 1'b1) begin n_fail++; $display("FAIL sw_we: got %b expected 1", o.we); end
        n_checks++; if (o.stall_cyc !== 8'd2) begin n_fail++; $display("FAIL sw_stall: got %0d expected 2", o.stall_cyc); end
        n_checks++; if (o.rdv_cnt !== 8'd0) begin n_fail++; $display("FAIL sw_rdvalid: got %0d expected 0", o.rdv_cnt); end
    endtask

    task automatic test_store_byte();
        obs_t o;
        drive_access(1'b0, 1'b1, 3'b000, 32'h103, 32'h0000_00A5, 32'h0, 0, 0, o);
        n_checks++; if (o.be !== 4'b1000) begin n_fail++; $display("FAIL sb_be: got %b expected 1000", o.be); end
        n_checks++; if (o.wdata !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL sb_wdata: got %h expected a5a5a5a5", o.wdata); end
        n_checks++; if (o.daddr !== 32'h100) begin n_fail++; $display("FAIL sb_addr: got %h expected 00000100", o.daddr); end
    endtask

    task automatic test_load_byte();
        obs_t o;
        drive_access(1'b1, 1'b0, 3'b000, 32'h102, 32'h0, 32'h0080_0000, 0, 3, o);
        n_checks++; if (o.rdata !== 32'hFFFFFF80) begin n_fail++; $display("FAIL lb_rdata: got %h expected ffffff80", o.rdata); end
        n_checks++; if (o.rdv !== 1'b1 || o.rdv_cnt !== 8'd1) begin
            n_fail++; $display("FAIL lb_rdvalid: got done=%b count=%0d expected 1/1", o.rdv, o.rdv_cnt);
        end
        n_checks++; if (o.stall_cyc !== 8'd5) begin n_fail++; $display("FAIL lb_stall: got %0d expected 5", o.stall_cyc); end
        n_checks++; if (o.to_cnt !== 8'd0) begin n_fail++; $display("FAIL lb_no_timeout: got %0d expected 0", o.to_cnt); end
        drive_access(1'b1, 1'b0, 3'b100, 32'h102, 32'h0, 32'h0080_0000, 0, 3, o);
        n_checks++; if (o.rdata !== 32'h0000_0080) begin n_fail++; $display("FAIL lbu_rdata: got %h expected 00000080", o.rdata); end
        last_rdata = 32'h0000_0080;
    endtask

    task automatic test_illegal();
        obs_t o;
        logic [2:0] f3s [3];
        logic       wrs [3];
        f3s = '{3'b010, 3'b011, 3'b010};
        wrs = '{1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            drive_access(1'b1, wrs[i], f3s[i], (i == 0) ? 32'h101 : 32'h100, 32'h0, 32'h0, 0, 0, o);
            n_checks++; if (o.err !== 1'b1) begin n_fail++; $display("FAIL illegal%0d_err: got %b expected 1", i, o.err); end
            n_checks++; if (o.req_cyc !== 8'd0 || o.stall_cyc !== 8'd0) begin
                n_fail++; $display("FAIL illegal%0d_quiet: got req=%0d stall=%0d expected 0/0", i, o.req_cyc, o.stall_cyc);
            end
        end
        #1;
        n_checks++; if (accessErr !== 1'b0) begin n_fail++; $display("FAIL illegal_err_clear: got %b expected 0", accessErr); end
    endtask

    task automatic test_timeout();
        obs_t o;
        drive_access(1'b1, 1'b0, 3'b010, 32'h200, 32'h0, 32'h1234_5678, 1000, 0, o);
        n_checks++; if (o.to !== 1'b1 || o.to_cnt !== 8'd1) begin
            n_fail++; $display("FAIL to_pulse: got done=%b count=%0d expected 1/1", o.to, o.to_cnt);
        end
        n_checks++; if (o.req_cyc !== 8'(TB_TIMEOUT)) begin n_fail++; $display("FAIL to_req_cycles: got %0d expected %0d", o.req_cyc, TB_TIMEOUT); end
        n_checks++; if (o.rdv_cnt !== 8'd0) begin n_fail++; $display("FAIL to_rdvalid: got %0d expected 0", o.rdv_cnt); end
        n_checks++; if (o.rdata !== 32'd0) begin n_fail++; $display("FAIL to_rdata: got %h expected 0", o.rdata); end
        n_checks++; if (o.post_idle !== 1'b1) begin n_fail++; $display("FAIL to_idle: got %b expected 1", o.post_idle); end
        last_rdata = '0;
    endtask

    task automatic test_random_back_to_back();
        obs_t o, e;
        logic rd, wr;
        logic [2:0] f3;
        logic [31:0] a, wd, rw;
        int rdy, rv, mode;
        for (int i = 0; i < 80; i++) begin
            mode = $urandom_range(0, 7);
            rd = (mode == 0) || (mode >= 2 && mode <= 4);
            wr = (mode == 0) || (mode >= 5);
            f3 = 3'($urandom_range(0, 7));
            a = $urandom(); wd = $urandom(); rw = $urandom();
            rdy = $urandom_range(0, 4); rv = $urandom_range(0, 4);
            e = model(rd, wr, f3, a, wd, rw, rdy, rv, last_rdata);
            drive_access(rd, wr, f3, a, wd, rw, rdy, rv, o);
            n_checks++; if (o.err !== e.err || o.stall_cyc !== e.stall_cyc || o.req_cyc !== e.req_cyc) begin
                n_fail++; $display("FAIL rnd%0d_flow: got err=%b stall=%0d req=%0d expected err=%b stall=%0d req=%0d",
                                   i, o.err, o.stall_cyc, o.req_cyc, e.err, e.stall_cyc, e.req_cyc);
            end
            if (e.done) begin
                n_checks++; if (o.daddr !== e.daddr || o.be !== e.be || o.we !== e.we || (wr && o.wdata !== e.wdata)) begin
                    n_fail++; $display("FAIL rnd%0d_bus: got a=%h be=%h we=%b wd=%h expected a=%h be=%h we=%b wd=%h",
                                       i, o.daddr, o.be, o.we, o.wdata, e.daddr, e.be, e.we, e.wdata);
                end
                n_checks++; if (o.done !== 1'b1 || o.rdata !== e.rdata || o.rdv_cnt !== e.rdv_cnt || o.to_cnt !== e.to_cnt || o.post_idle !== 1'b1) begin
                    n_fail++; $display("FAIL rnd%0d_result: got done=%b rdata=%h rdv=%0d to=%0d idle=%b expected rdata=%h rdv=%0d to=%0d",
                                       i, o.done, o.rdata, o.rdv_cnt, o.to_cnt, o.post_idle, e.rdata, e.rdv_cnt, e.to_cnt);
                end
                last_rdata = e.rdata;
            end
        end
    endtask

    task automatic test_reset_in_resp();
        int late;
        memRead = 1'b1; memWrite = 1'b0; cmdF3 = 3'b010; addr = 32'h100;
        @(negedge clk);
        dmemReady = 1'b1;
        @(negedge clk);
        dmemReady = 1'b0;
        n_checks++; if (stall !== 1'b1 || dmemReq !== 1'b0) begin
            n_fail++; $display("FAIL rr_in_resp: got stall=%b req=%b expected 1/0", stall, dmemReq);
        end
        @(negedge clk);
        rst_n = 1'b0; memRead = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n_checks++; if (stall !== 1'b0 || dmemReq !== 1'b0) begin
            n_fail++; $display("FAIL rr_idle: got stall=%b req=%b expected 0/0", stall, dmemReq);
        end
        n_checks++; if (rdata !== 32'd0) begin n_fail++; $display("FAIL rr_rdata: got %h expected 0", rdata); end
        dmemRvalid = 1'b1; dmemRdata = 32'hCAFE_F00D;
        late = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            dmemRvalid = 1'b0;
            if (rdValid) late++;
        end
        n_checks++; if (late !== 0) begin n_fail++; $display("FAIL rr_late_rvalid: got %0d rdValid cycles expected 0", late); end
    endtask

    initial begin
        rst_n = 1'b0; memRead = 1'b0; memWrite = 1'b0; cmdF3 = '0; addr = '0; wdataIn = '0;
        dmemReady = 1'b0; dmemRvalid = 1'b0; dmemRdata = '0;
        @(negedge clk);
        test_reset();
        test_store_word();
        test_store_byte();
        test_load_byte();
        test_illegal();
        test_timeout();
        test_random_back_to_back();
        test_reset_in_resp();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
